seq_detect_prog: RTL and testbench

Runtime-programmable serial bit-pattern detector. It is the parametrised successor of the fixed 4-bit sequence detector.
- Pattern and length are loaded at runtime, up to MAX_LEN bits.
- Overlapping or non-overlapping detection is selectable.
- Input is qualified by a valid strobe.
- A saturating match counter is provided.
- It sits on serial bitstream paths as a frame-marker or sync-word detector.

---
 rtl/seq_detect_pkg.sv | 28 ++
 rtl/seq_hist_shreg.sv | 52 +++++
 rtl/seq_detect_prog.sv | 106 ++++++++++
 tb/tb_seq_detect_prog.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable sequence detector:
// FSM state type, length clamp and length-mask helpers.
package seq_detect_pkg;

   typedef enum logic {
      ST_UNARMED = 1'b0,
      ST_ARMED   = 1'b1
   } state_t;

   // Widest pattern the mask helper can describe.
   localparam int unsigned MASK_W = 64;

   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

   // Ones in the low 'len' bit positions, zeros above.
   function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MASK_W; i++) begin
         if (i < len) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// History shift register plus saturating fill counter for the detector.
// Exposes the post-shift history and fill so the compare can act on the
// bit being accepted in the same cycle.
module seq_hist_shreg #(
   parameter int unsigned  MAX_LEN = 8,
   localparam int unsigned FILL_W  = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_shift,
   input  logic               i_clr,
   input  logic               i_fill_rst,
   input  logic               i_bit,
   output logic [MAX_LEN-1:0] o_hist_next,
   output logic [FILL_W-1:0]  o_fill_next
);

   logic [MAX_LEN-1:0] r_hist;
   logic [FILL_W-1:0]  r_fill;
   logic [MAX_LEN-1:0] w_shifted;

   generate
      if (MAX_LEN == 1) begin : g_one
         assign w_shifted = i_bit;
      end else begin : g_many
         assign w_shifted = {r_hist[MAX_LEN-2:0], i_bit};
      end
   endgenerate

   // Next history and saturating fill for the current input bit.
   always_comb begin
      o_hist_next = r_hist;
      o_fill_next = r_fill;
      if (i_shift) begin
         o_hist_next = w_shifted;
         if (r_fill != FILL_W'(MAX_LEN)) o_fill_next = r_fill + 1'b1;
      end
   end

   // History and fill registers; fill reset overrides the increment.
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_hist <= '0;
         r_fill <= '0;
      end else begin
         r_hist <= o_hist_next;
         if (i_fill_rst) r_fill <= '0;
         else            r_fill <= o_fill_next;
      end
   end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap select and
// saturating match counter.
// Optional: define SEQ_DETECT_CNT_CLR_EN to add the cnt_clr input.
module seq_detect_prog
   import seq_detect_pkg::*;
#(
   parameter int unsigned  MAX_LEN = 8,
   parameter int unsigned  CNT_W   = 16,
   localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               inp_bit,
`ifdef SEQ_DETECT_CNT_CLR_EN
   input  logic               cnt_clr,
`endif
   output logic               seq_seen,
   output logic               armed,
   output logic [CNT_W-1:0]   match_count
);

   state_t             r_state;
   logic [MAX_LEN-1:0] r_pattern;
   logic [LEN_W-1:0]   r_len;
   logic               r_overlap;
   logic               r_seen;
   logic [CNT_W-1:0]   r_count;

   logic               w_shift;
   logic               w_match;
   logic [LEN_W-1:0]   w_len_clamped;
   logic [MAX_LEN-1:0] w_mask;
   logic [MAX_LEN-1:0] w_hist_next;
   logic [LEN_W-1:0]   w_fill_next;

   // A config load discards the bit offered in the same cycle.
   assign w_shift       = in_valid & ~cfg_load;
   assign w_len_clamped = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
   assign w_mask        = MAX_LEN'(len_mask(32'(r_len)));

   seq_hist_shreg #(
      .MAX_LEN (MAX_LEN)
   ) u_hist (
      .clk         (clk),
      .reset       (reset),
      .i_shift     (w_shift),
      .i_clr       (cfg_load),
      .i_fill_rst  (w_match & ~r_overlap),
      .i_bit       (inp_bit),
      .o_hist_next (w_hist_next),
      .o_fill_next (w_fill_next)
   );

   // Match on the history as it will be after accepting this bit.
   always_comb begin
      w_match = 1'b0;
      if ((r_state == ST_ARMED) && w_shift && (w_fill_next >= r_len) &&
          ((w_hist_next & w_mask) == (r_pattern & w_mask))) begin
         w_match = 1'b1;
      end
   end

   // FSM and configuration registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_UNARMED;
         r_pattern <= '0;
         r_len     <= '0;
         r_overlap <= 1'b0;
      end else if (cfg_load) begin
         r_state   <= (cfg_len == '0) ? ST_UNARMED : ST_ARMED;
         r_pattern <= cfg_pattern;
         r_len     <= w_len_clamped;
         r_overlap <= cfg_overlap;
      end
   end

   // Registered one-cycle match pulse; w_match is already low on cfg_load.
   always_ff @(posedge clk) begin
      if (reset) r_seen <= 1'b0;
      else       r_seen <= w_match;
   end

   // Saturating match counter.
   always_ff @(posedge clk) begin
      if (reset || cfg_load) begin
         r_count <= '0;
`ifdef SEQ_DETECT_CNT_CLR_EN
      end else if (cnt_clr) begin
         r_count <= '0;
`endif
      end else if (w_match && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign seq_seen    = r_seen;
   assign armed       = (r_state == ST_ARMED);
   assign match_count = r_count;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Table-driven self-checking bench for seq_detect_prog (MAX_LEN=8, CNT_W=2).
// Honours SEQ_DETECT_CNT_CLR_EN when defined.
module tb_seq_detect_prog;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned LEN_W   = 4;

   logic               clk;
   logic               reset;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               in_valid;
   logic               inp_bit;
`ifdef SEQ_DETECT_CNT_CLR_EN
   logic               cnt_clr;
`endif
   logic               seq_seen;
   logic               armed;
   logic [CNT_W-1:0]   match_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      logic       rst;
      logic       ld;
      logic [7:0] pat;
      logic [3:0] len;
      logic       ov;
      logic       v;
      logic       b;
      logic       clr;
      logic       e_seen;
      logic       e_armed;
      logic [1:0] e_cnt;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   seq_detect_prog #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .in_valid    (in_valid),
      .inp_bit     (inp_bit),
`ifdef SEQ_DETECT_CNT_CLR_EN
      .cnt_clr     (cnt_clr),
`endif
      .seq_seen    (seq_seen),
      .armed       (armed),
      .match_count (match_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input string name, input logic rst, input logic ld,
                               input logic [7:0] pat, input logic [3:0] len,
                               input logic ov, input logic v, input logic b,
                               input logic clr, input logic es, input logic ea,
                               input logic [1:0] ec);
      vec_t t;
      t.name = name; t.rst = rst; t.ld = ld; t.pat = pat; t.len = len;
      t.ov = ov; t.v = v; t.b = b; t.clr = clr;
      t.e_seen = es; t.e_armed = ea; t.e_cnt = ec;
      return t;
   endfunction

   // Shorthands: a data bit, an idle cycle, a config load.
   function automatic vec_t bt(input string n, input logic b, input logic es,
                               input logic ea, input logic [1:0] ec);
      return mk(n, 0, 0, 8'h00, 4'd0, 0, 1, b, 0, es, ea, ec);
   endfunction

   function automatic vec_t ld(input string n, input logic [7:0] pat,
                               input logic [3:0] len, input logic ov, input logic ea);
      return mk(n, 0, 1, pat, len, ov, 0, 0, 0, 0, ea, 2'd0);
   endfunction

   task automatic apply(input vec_t t);
      vec_t e;
      @(negedge clk);
      reset       = t.rst;
      cfg_load    = t.ld;
      cfg_pattern = t.pat;
      cfg_len     = t.len;
      cfg_overlap = t.ov;
      in_valid    = t.v;
      inp_bit     = t.b;
`ifdef SEQ_DETECT_CNT_CLR_EN
      cnt_clr     = t.clr;
`endif
      sb.push_back(t);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (seq_seen !== e.e_seen) begin
         errors++;
         $display("FAIL %s seq_seen got=%0b exp=%0b", e.name, seq_seen, e.e_seen);
      end
      checks++;
      if (armed !== e.e_armed) begin
         errors++;
         $display("FAIL %s armed got=%0b exp=%0b", e.name, armed, e.e_armed);
      end
      checks++;
      if (match_count !== e.e_cnt) begin
         errors++;
         $display("FAIL %s match_count got=%0d exp=%0d", e.name, match_count, e.e_cnt);
      end
   endtask

   initial begin
      reset = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
      cfg_overlap = 1'b0; in_valid = 1'b0; inp_bit = 1'b0;
`ifdef SEQ_DETECT_CNT_CLR_EN
      cnt_clr = 1'b0;
`endif

      // 1: reset, stream without configuration
      vecs.push_back(mk("t1_reset", 1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 2'd0));
      vecs.push_back(bt("t1_b1", 1, 0, 0, 2'd0));
      vecs.push_back(bt("t1_b2", 0, 0, 0, 2'd0));
      vecs.push_back(bt("t1_b3", 1, 0, 0, 2'd0));
      vecs.push_back(bt("t1_b4", 1, 0, 0, 2'd0));
      // 2: 1011 overlapping
      vecs.push_back(ld("t2_load", 8'b1011, 4'd4, 1, 1));
      vecs.push_back(bt("t2_b1", 1, 0, 1, 2'd0));
      vecs.push_back(bt("t2_b2", 0, 0, 1, 2'd0));
      vecs.push_back(bt("t2_b3", 1, 0, 1, 2'd0));
      vecs.push_back(bt("t2_b4", 1, 1, 1, 2'd1));
      vecs.push_back(bt("t2_b5", 0, 0, 1, 2'd1));
      vecs.push_back(bt("t2_b6", 1, 0, 1, 2'd1));
      vecs.push_back(bt("t2_b7", 1, 1, 1, 2'd2));
      // 3: 1011 non-overlapping
      vecs.push_back(ld("t3_load", 8'b1011, 4'd4, 0, 1));
      vecs.push_back(bt("t3_b1", 1, 0, 1, 2'd0));
      vecs.push_back(bt("t3_b2", 0, 0, 1, 2'd0));
      vecs.push_back(bt("t3_b3", 1, 0, 1, 2'd0));
      vecs.push_back(bt("t3_b4", 1, 1, 1, 2'd1));
      vecs.push_back(bt("t3_b5", 0, 0, 1, 2'd1));
      vecs.push_back(bt("t3_b6", 1, 0, 1, 2'd1));
      vecs.push_back(bt("t3_b7", 1, 0, 1, 2'd1));
      // 4: len=1 with invalid gaps
      vecs.push_back(ld("t4_load", 8'b1, 4'd1, 1, 1));
      vecs.push_back(bt("t4_b1", 1, 1, 1, 2'd1));
      vecs.push_back(bt("t4_b2", 1, 1, 1, 2'd2));
      vecs.push_back(mk("t4_gap1", 0, 0, 8'h00, 4'd0, 0, 0, 1, 0, 0, 1, 2'd2));
      vecs.push_back(mk("t4_gap2", 0, 0, 8'h00, 4'd0, 0, 0, 1, 0, 0, 1, 2'd2));
      vecs.push_back(bt("t4_b3", 0, 0, 1, 2'd2));
      vecs.push_back(bt("t4_b4", 1, 1, 1, 2'd3));
      // 5: reload mid-pattern discards history and the coincident bit
      vecs.push_back(ld("t5_load", 8'b1011, 4'd4, 1, 1));
      vecs.push_back(bt("t5_b1", 1, 0, 1, 2'd0));
      vecs.push_back(bt("t5_b2", 0, 0, 1, 2'd0));
      vecs.push_back(bt("t5_b3", 1, 0, 1, 2'd0));
      vecs.push_back(mk("t5_reload", 0, 1, 8'b1011, 4'd4, 1, 1, 1, 0, 0, 1, 2'd0));
      vecs.push_back(bt("t5_b4", 1, 0, 1, 2'd0));
      vecs.push_back(ld("t5_len0", 8'b1011, 4'd0, 1, 0));
      // length above MAX_LEN clamps to 8: 8'hA5 sent MSB first
      vecs.push_back(ld("clamp_load", 8'hA5, 4'd15, 1, 1));
      vecs.push_back(bt("clamp_b1", 1, 0, 1, 2'd0));
      vecs.push_back(bt("clamp_b2", 0, 0, 1, 2'd0));
      vecs.push_back(bt("clamp_b3", 1, 0, 1, 2'd0));
      vecs.push_back(bt("clamp_b4", 0, 0, 1, 2'd0));
      vecs.push_back(bt("clamp_b5", 0, 0, 1, 2'd0));
      vecs.push_back(bt("clamp_b6", 1, 0, 1, 2'd0));
      vecs.push_back(bt("clamp_b7", 0, 0, 1, 2'd0));
      vecs.push_back(bt("clamp_b8", 1, 1, 1, 2'd1));
      // 6: saturation at 3, then reset with a completing bit
      vecs.push_back(ld("t6_load", 8'b1, 4'd1, 1, 1));
      vecs.push_back(bt("t6_b1", 1, 1, 1, 2'd1));
      vecs.push_back(bt("t6_b2", 1, 1, 1, 2'd2));
      vecs.push_back(bt("t6_b3", 1, 1, 1, 2'd3));
      vecs.push_back(bt("t6_b4", 1, 1, 1, 2'd3));
      vecs.push_back(bt("t6_b5", 1, 1, 1, 2'd3));
      vecs.push_back(mk("t6_reset", 1, 0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 0, 2'd0));
      vecs.push_back(bt("t6_after", 1, 0, 0, 2'd0));
`ifdef SEQ_DETECT_CNT_CLR_EN
      vecs.push_back(ld("clr_load", 8'b1, 4'd1, 1, 1));
      vecs.push_back(bt("clr_b1", 1, 1, 1, 2'd1));
      vecs.push_back(mk("clr_hit", 0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 1, 2'd0));
      vecs.push_back(bt("clr_b3", 1, 1, 1, 2'd1));
`endif

      foreach (vecs[i]) apply(vecs[i]);

      // Hand-written: pattern 11, non-overlap needs two fresh bits per match
      apply(ld("h_no_load", 8'b11, 4'd2, 0, 1));
      apply(bt("h_no_b1", 1, 0, 1, 2'd0));
      apply(bt("h_no_b2", 1, 1, 1, 2'd1));
      apply(bt("h_no_b3", 1, 0, 1, 2'd1));
      apply(bt("h_no_b4", 1, 1, 1, 2'd2));
      // Hand-written: same pattern overlapping matches on every bit after the first
      apply(ld("h_ov_load", 8'b11, 4'd2, 1, 1));
      apply(bt("h_ov_b1", 1, 0, 1, 2'd0));
      apply(bt("h_ov_b2", 1, 1, 1, 2'd1));
      apply(bt("h_ov_b3", 1, 1, 1, 2'd2));
      apply(mk("h_ov_idle", 0, 0, 8'h00, 4'd0, 0, 0, 1, 0, 0, 1, 2'd2));
      apply(bt("h_ov_b4", 0, 0, 1, 2'd2));
      apply(bt("h_ov_b5", 1, 0, 1, 2'd2));
      apply(bt("h_ov_b6", 1, 1, 1, 2'd3));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
